// File: rtl/gb_alu_pkg.sv
// Shared definitions for the 8-bit ALU interface and the 16-bit sequencer:
// ALU op codes, flag bit positions, the 16-bit op encoding and FSM states.
package gb_alu_pkg;

  // 8-bit ALU op codes driven on alu_op
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_ADC    = 5'b00001;
  localparam logic [4:0] ALU_SUB    = 5'b00010;
  localparam logic [4:0] ALU_SBC    = 5'b00011;
  localparam logic [4:0] ALU_AND    = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_OR     = 5'b00110;
  localparam logic [4:0] ALU_CP     = 5'b00111;
  localparam logic [4:0] ALU_COPY_A = 5'b11000;

  // Flag bit positions inside a 4-bit CHNZ flag word
  localparam int FLAG_C = 0;
  localparam int FLAG_H = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  // 16-bit operation selected by the control unit
  typedef enum logic [1:0] {
    OP_ADD16 = 2'd0,
    OP_INC16 = 2'd1,
    OP_DEC16 = 2'd2,
    OP_ADDSP = 2'd3
  } alu16_op_t;

  // Sequencer states: one ALU pass per byte, then a done cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } alu16_state_t;

  // ALU op for the low-byte pass: decrement subtracts, everything else adds
  function automatic logic [4:0] lo_alu_op(input alu16_op_t op);
    return (op == OP_DEC16) ? ALU_SUB : ALU_ADD;
  endfunction

  // ALU op for the high-byte pass: propagate the low-byte carry/borrow
  function automatic logic [4:0] hi_alu_op(input alu16_op_t op);
    return (op == OP_DEC16) ? ALU_SBC : ALU_ADC;
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// 16-bit arithmetic sequencer: runs the shared 8-bit ALU over the low byte
// and then the high byte, chaining the carry, and assembles result/flags.
module alu16_seq
  import gb_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  input  logic [3:0]  flag_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flag_out,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_op,
  output logic [3:0]  alu_flag_in,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flag_out
);

  alu16_state_t r_state;
  alu16_op_t    r_op;
  logic [15:0]  r_a;
  logic [15:0]  r_b;
  logic [3:0]   r_flags;
  logic         r_lo_c;
  logic         r_lo_h;
  logic         r_busy;
  logic         r_done;
  logic [15:0]  r_result;
  logic [3:0]   r_flag_out;

  logic [3:0]   w_flag_next;
  logic         w_unused_flags;

  // N and Z from the ALU never feed the 16-bit flags
  assign w_unused_flags = &{1'b0, alu_flag_out[FLAG_N], alu_flag_out[FLAG_Z]};

  // Drive the shared ALU from the current state and the latched operands
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_op      = ALU_COPY_A;
    alu_flag_in = 4'h0;
    case (r_state)
      ST_LO: begin
        alu_a               = r_a[7:0];
        alu_flag_in         = r_flags;
        alu_flag_in[FLAG_C] = 1'b0;
        alu_op              = lo_alu_op(r_op);
        case (r_op)
          OP_INC16, OP_DEC16: alu_b = 8'h01;
          default:            alu_b = r_b[7:0];
        endcase
      end
      ST_HI: begin
        alu_a               = r_a[15:8];
        alu_flag_in         = r_flags;
        alu_flag_in[FLAG_C] = r_lo_c;
        alu_op              = hi_alu_op(r_op);
        case (r_op)
          OP_ADD16: alu_b = r_b[15:8];
          OP_ADDSP: alu_b = {8{r_b[7]}};
          default:  alu_b = 8'h00;
        endcase
      end
      default: begin
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_op      = ALU_COPY_A;
        alu_flag_in = 4'h0;
      end
    endcase
  end

  // Final 16-bit flags, valid during the HI pass
  always_comb begin
    w_flag_next = r_flags;
    case (r_op)
      OP_ADD16: begin
        w_flag_next[FLAG_Z] = r_flags[FLAG_Z];
        w_flag_next[FLAG_N] = 1'b0;
        w_flag_next[FLAG_H] = alu_flag_out[FLAG_H];
        w_flag_next[FLAG_C] = alu_flag_out[FLAG_C];
      end
      OP_ADDSP: begin
        // Flags come from the unsigned low-byte add; the high pass is discarded
        w_flag_next[FLAG_Z] = 1'b0;
        w_flag_next[FLAG_N] = 1'b0;
        w_flag_next[FLAG_H] = r_lo_h;
        w_flag_next[FLAG_C] = r_lo_c;
      end
      default: w_flag_next = r_flags;
    endcase
  end

  // Sequencer FSM: latch on start, capture each byte pass, pulse done
  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_ADD16;
      r_a        <= 16'h0000;
      r_b        <= 16'h0000;
      r_flags    <= 4'h0;
      r_lo_c     <= 1'b0;
      r_lo_h     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 16'h0000;
      r_flag_out <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op    <= alu16_op_t'(op);
            r_a     <= operand_a;
            r_b     <= operand_b;
            r_flags <= flag_in;
            r_busy  <= 1'b1;
            r_state <= ST_LO;
          end
        end
        ST_LO: begin
          r_result[7:0] <= alu_out;
          r_lo_c        <= alu_flag_out[FLAG_C];
          r_lo_h        <= alu_flag_out[FLAG_H];
          r_state       <= ST_HI;
        end
        ST_HI: begin
          r_result[15:8] <= alu_out;
          r_flag_out     <= w_flag_next;
          r_busy         <= 1'b0;
          r_done         <= 1'b1;
          r_state        <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign flag_out = r_flag_out;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: a behavioural 8-bit ALU sits behind the sequencer,
// a driver issues directed operations, a monitor scores every done pulse.
module tb_alu16_seq;
  import gb_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a, operand_b;
  logic [3:0]  flag_in;
  logic        busy, done;
  logic [15:0] result;
  logic [3:0]  flag_out;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic [3:0]  alu_flag_in, alu_flag_out;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_count = 0;

  alu16_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flag_in(flag_in),
    .busy(busy), .done(done), .result(result), .flag_out(flag_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flag_in(alu_flag_in),
    .alu_out(alu_out), .alu_flag_out(alu_flag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-bit ALU (flags CHNZ, C=1 means borrow on subtract)
  always_comb begin
    logic [8:0] s;
    logic [4:0] hs;
    logic       cin;
    s = 9'h000;
    hs = 5'h00;
    cin = 1'b0;
    alu_out = alu_a;
    alu_flag_out = alu_flag_in;
    case (alu_op)
      ALU_ADD, ALU_ADC: begin
        cin = (alu_op == ALU_ADC) ? alu_flag_in[0] : 1'b0;
        s  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, cin};
        hs = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, cin};
        alu_out = s[7:0];
        alu_flag_out = {(s[7:0] == 8'h00), 1'b0, hs[4], s[8]};
      end
      ALU_SUB, ALU_SBC: begin
        cin = (alu_op == ALU_SBC) ? alu_flag_in[0] : 1'b0;
        s  = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, cin};
        hs = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'h0, cin};
        alu_out = s[7:0];
        alu_flag_out = {(s[7:0] == 8'h00), 1'b1, hs[4], s[8]};
      end
      default: begin
        alu_out = alu_a;
        alu_flag_out = alu_flag_in;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: score every done pulse against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_count++;
        if (exp_q.size() == 0) begin
          check("sb unexpected done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb result", 32'(result), 32'(e.res));
          check("sb flags", 32'(flag_out), 32'(e.flg));
          check("sb latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Issue one operation; caller is just past a negedge
  task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f,
                        input logic [15:0] er, input logic [3:0] ef);
    exp_t e;
    e.res = er;
    e.flg = ef;
    e.cyc = cyc + 3;
    exp_q.push_back(e);
    op = o; operand_a = a; operand_b = b; flag_in = f; start = 1'b1;
    @(posedge clk); #1;
    check({name, " busy LO"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({name, " busy HI"}, 32'({busy, done}), 32'b10);
    @(posedge clk); #1;
    check({name, " done pulse"}, 32'({busy, done}), 32'b01);
    @(posedge clk); #1;
    check({name, " idle after"}, 32'({busy, done}), 32'b00);
    check({name, " result held"}, 32'(result), 32'(er));
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int dc;
    // Reset with start asserted: the request must be lost
    reset = 1'b1; start = 1'b1; op = 2'd0;
    operand_a = 16'h0FFF; operand_b = 16'h0001; flag_in = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("reset busy/done", 32'({busy, done}), 32'b00);
    check("reset result", 32'(result), 32'h0000);
    check("reset flags", 32'(flag_out), 32'h0);
    check("idle alu_op", 32'(alu_op), 32'h18);
    check("idle alu_a/b/f", 32'({alu_a, alu_b, alu_flag_in}), 32'h0);
    @(posedge clk); #1;
    check("start during reset lost", 32'(busy), 32'd0);
    @(negedge clk);

    // Directed operations
    run_op("add16 half", 2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
    run_op("add16 wrap", 2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
    run_op("addsp +8",   2'd3, 16'hFFF8, 16'h0008, 4'b1100, 16'h0000, 4'b0011);
    run_op("addsp -1",   2'd3, 16'h0000, 16'hABFF, 4'b0000, 16'hFFFF, 4'b0000);
    run_op("addsp -16",  2'd3, 16'h1234, 16'h00F0, 4'b0000, 16'h1224, 4'b0001);
    run_op("inc16 wrap", 2'd1, 16'hFFFF, 16'h1234, 4'b0101, 16'h0000, 4'b0101);
    run_op("dec16 wrap", 2'd2, 16'h0000, 16'h5678, 4'b1010, 16'hFFFF, 4'b1010);
    run_op("dec16 byte", 2'd2, 16'h1000, 16'h0000, 4'b0000, 16'h0FFF, 4'b0000);

    // start held for 6 cycles: accepted at the 1st and 5th edges only
    dc = done_count;
    e.res = 16'h2345; e.flg = 4'b0000; e.cyc = cyc + 3; exp_q.push_back(e);
    e.res = 16'h0000; e.flg = 4'b0001; e.cyc = cyc + 7; exp_q.push_back(e);
    start = 1'b1; op = 2'd0; operand_a = 16'h1234; operand_b = 16'h1111; flag_in = 4'b0000;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) begin
        op = 2'd0; operand_a = 16'h8000; operand_b = 16'h8000; flag_in = 4'b0100;
      end else begin
        op = (i == 5) ? 2'd1 : 2'd2; operand_a = 16'hAAAA; operand_b = 16'h5555; flag_in = 4'b1111;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("held start done count", 32'(done_count - dc), 32'd2);

    // Reset in HI aborts the operation and clears outputs
    run_op("pre-reset dec", 2'd2, 16'h0000, 16'h0000, 4'b1010, 16'hFFFF, 4'b1010);
    op = 2'd0; operand_a = 16'h0FFF; operand_b = 16'h0001; flag_in = 4'b1000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("abort in HI busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy/done", 32'({busy, done}), 32'b00);
    check("abort result", 32'(result), 32'h0000);
    check("abort flags", 32'(flag_out), 32'h0);
    dc = done_count;
    @(negedge clk);
    reset = 1'b0;
    // start on the first non-reset edge must be accepted
    run_op("inc after reset", 2'd1, 16'hFFFF, 16'h0000, 4'b0101, 16'h0000, 4'b0101);
    repeat (3) @(negedge clk);
    check("one done after abort", 32'(done_count - dc), 32'd1);
    check("sb drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Multi-cycle sequencer that performs the CPU's 16-bit arithmetic (ADD HL,rr; INC rr; DEC rr; ADD SP,e / LD HL,SP+e) by driving the shared 8-bit ALU twice: low byte, then high byte.
- It is the initiator side of the 8-bit ALU's op/operand/flag interface.
- It sits beside the CPU control unit, which starts it, and owns the ALU inputs while busy.

Parameters:
- None.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- op  in  2  0=ADD16, 1=INC16, 2=DEC16, 3=ADDSP
- operand_a  in  16  HL or SP or rr (INC/DEC source)
- operand_b  in  16  rr for ADD16; [7:0] = signed e8 for ADDSP; ignored for INC16/DEC16
- flag_in  in  4  current CPU flags, CHNZ order (bit0 C, bit1 H, bit2 N, bit3 Z)
- busy  out  1  high in LO and HI states; ALU driven by this block
- done  out  1  one-cycle pulse; result/flag_out valid
- result  out  16  16-bit result, held until the next accepted start
- flag_out  out  4  new CPU flags, CHNZ, held like result
- alu_a  out  8  to ALU first operand
- alu_b  out  8  to ALU second operand
- alu_op  out  5  to ALU op code
- alu_flag_in  out  4  to ALU flags input
- alu_out  in  8  from ALU result
- alu_flag_out  in  4  from ALU flags

Behaviour:
- States: IDLE -> LO -> HI -> DONE -> IDLE. Transitions are unconditional except IDLE -> LO, which requires start=1.
- On start in IDLE, latch op, operand_a, operand_b and flag_in. start outside IDLE is ignored: no queueing, no effect on the current operation.
- Latency: start sampled at edge k gives LO in cycle k+1, HI in k+2, DONE (done=1) in k+3, IDLE in k+4. Back-to-back operation costs 4 cycles.
- IDLE/DONE ALU drive: alu_op=COPY_A (5'b11000), alu_a=alu_b=0, alu_flag_in=0.
- LO step:
  - alu_a = A[7:0]; alu_flag_in = latched flags with C forced 0.
  - ADD16/ADDSP: alu_b = B[7:0], alu_op = ADD (00000).
  - INC16: alu_b = 0x01, alu_op = ADD.
  - DEC16: alu_b = 0x01, alu_op = SUB (00010).
  - End of cycle: capture alu_out into result[7:0]; capture alu_flag_out C and H into lo_c and lo_h.
- HI step:
  - alu_a = A[15:8]; alu_flag_in = latched flags with C replaced by lo_c.
  - ADD16: alu_b = B[15:8], alu_op = ADC (00001).
  - INC16: alu_b = 0x00, alu_op = ADC.
  - DEC16: alu_b = 0x00, alu_op = SBC (00011). The ALU's C=1 means borrow.
  - ADDSP: alu_b = {8{B[7]}} (sign extension), alu_op = ADC.
  - End of cycle: capture alu_out into result[15:8]; compute flag_out.
- flag_out per op:
  - ADD16: Z = latched Z; N = 0; H, C = HI-step ALU H, C (carry out of bits 11 and 15).
  - INC16/DEC16: flag_out = latched flag_in, unchanged.
  - ADDSP: Z = 0; N = 0; H = lo_h; C = lo_c (unsigned low-byte add); high-step flags discarded.
- Wrap-around: all arithmetic is modulo 2^16; no saturation.
- result and flag_out change only at the end of HI. They stay stable through DONE and IDLE.
- Reset (any state, including mid-operation): state IDLE; busy=0, done=0, result=0x0000, flag_out=0, lo_c=lo_h=0; latched operands cleared. A start asserted during reset is lost.
- A start arriving the same cycle reset deasserts (first non-reset edge) is accepted normally.

Decomposition:
- Shared package gb_alu_pkg holds:
  - the 5-bit ALU op constants (ADD, ADC, SUB, SBC, COPY_A, ...);
  - the flag index constants C=0, H=1, N=2, Z=3;
  - the 2-bit alu16_op enum (ADD16, INC16, DEC16, ADDSP);
  - the state enum.
- No sub-module. The 8-bit ALU stays external because the 8-bit datapath shares it; the bench instantiates the real ALU behind this block.

Test Plan:
- ADD16, A=0x0FFF, B=0x0001, flag_in=4'b1000 -> done at k+3; result=0x1000; flag_out=4'b1010 (Z kept, H=1, C=0).
- ADD16, A=0xFFFF, B=0x0001, flag_in=0 -> result=0x0000, flag_out=4'b0011 (Z not set despite zero result).
- ADDSP: A=0xFFF8, e=0x08 -> result=0x0000, flag_out=4'b0011. A=0x0000, e=0xFF -> result=0xFFFF, flag_out=4'b0000.
- INC16 A=0xFFFF, flag_in=4'b0101 -> result=0x0000, flag_out=4'b0101. DEC16 A=0x0000 -> result=0xFFFF, flags unchanged.
- Protocol: start held high for 6 cycles -> exactly one done per 4 cycles; busy high exactly in LO/HI; start asserted during busy has no effect on result.
- Reset asserted in HI -> next cycle busy=0, done=0, result=0, flag_out=0. No done pulse follows. A new start then completes normally.
